// File: rtl/clk_gate_ctrl.sv
// Per-domain clock-gating sequencer: idle hysteresis before gating, settle delay before wake_ack.
// Define CLK_GATE_STAT_EN to enable the per-domain gated-cycle statistics counters.
module clk_gate_ctrl #(
  parameter int unsigned NUM_DOM  = 4,
  parameter int unsigned IDLE_CYC = 16,
  parameter int unsigned WAKE_CYC = 2,
  parameter int unsigned STAT_W   = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        glb_gate_en,
  input  logic [NUM_DOM-1:0]          force_on,
  input  logic [NUM_DOM-1:0]          dom_idle,
  input  logic [NUM_DOM-1:0]          wake_req,
  output logic [NUM_DOM-1:0]          wake_ack,
  output logic [NUM_DOM-1:0]          local_en,
  output logic [2*NUM_DOM-1:0]        dom_state,
  input  logic                        stat_clr,
  output logic [STAT_W*NUM_DOM-1:0]   gated_cyc
);

  localparam int unsigned MAX_CYC = (IDLE_CYC > WAKE_CYC) ? IDLE_CYC : WAKE_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);

  typedef enum logic [1:0] {
    ST_ON   = 2'b00,
    ST_HYST = 2'b01,
    ST_OFF  = 2'b10,
    ST_WAKE = 2'b11
  } state_t;

  state_t             state_q [NUM_DOM];
  state_t             state_d [NUM_DOM];
  logic [CNT_W-1:0]   cnt_q   [NUM_DOM];
  logic [CNT_W-1:0]   cnt_d   [NUM_DOM];
  logic [NUM_DOM-1:0] allow;

  assign allow = {NUM_DOM{glb_gate_en}} & ~force_on;

  // State and hysteresis/settle counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DOM; i++) begin
        state_q[i] <= ST_ON;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_DOM; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state: any reason to keep the clock running aborts or ends gating
  always_comb begin
    for (int i = 0; i < NUM_DOM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_ON: begin
          if (allow[i] && dom_idle[i] && !wake_req[i]) begin
            state_d[i] = ST_HYST;
            cnt_d[i]   = IDLE_LOAD;
          end
        end
        ST_HYST: begin
          if (!allow[i] || !dom_idle[i] || wake_req[i]) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ST_OFF;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        ST_OFF: begin
          if (!allow[i] || !dom_idle[i] || wake_req[i]) begin
            state_d[i] = ST_WAKE;
            cnt_d[i]   = WAKE_LOAD;
          end
        end
        ST_WAKE: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = ST_ON;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_ON;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Outputs decoded straight from the state register; ack is masked while reset is held
  always_comb begin
    local_en  = '0;
    wake_ack  = '0;
    dom_state = '0;
    for (int i = 0; i < NUM_DOM; i++) begin
      local_en[i]         = (state_q[i] != ST_OFF);
      wake_ack[i]         = wake_req[i] && (state_q[i] == ST_ON) && !rst;
      dom_state[2*i +: 2] = state_q[i];
    end
  end

`ifdef CLK_GATE_STAT_EN
  logic [STAT_W-1:0] stat_q [NUM_DOM];

  // Saturating gated-cycle counters; clear takes priority over counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DOM; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_DOM; i++) begin
        if (stat_clr) begin
          stat_q[i] <= '0;
        end else if ((state_q[i] == ST_OFF) && (stat_q[i] != {STAT_W{1'b1}})) begin
          stat_q[i] <= stat_q[i] + STAT_W'(1);
        end
      end
    end
  end

  always_comb begin
    gated_cyc = '0;
    for (int i = 0; i < NUM_DOM; i++) begin
      gated_cyc[STAT_W*i +: STAT_W] = stat_q[i];
    end
  end
`else
  logic unused_stat_clr;

  assign unused_stat_clr = stat_clr;
  assign gated_cyc       = '0;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl (NUM_DOM=2, IDLE_CYC=4, WAKE_CYC=2, STAT_W=4).
// Stat expectations follow CLK_GATE_STAT_EN: counts when defined, zero otherwise.
module tb_clk_gate_ctrl;

  localparam int unsigned ND = 2;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          glb_gate_en;
  logic [ND-1:0] force_on, dom_idle, wake_req, wake_ack, local_en;
  logic [2*ND-1:0]  dom_state;
  logic             stat_clr;
  logic [SW*ND-1:0] gated_cyc;

  typedef struct {
    logic       glb;
    logic [1:0] frc;
    logic [1:0] idl;
    logic [1:0] wrq;
    logic       clr;
    logic [3:0] st;
    logic [1:0] len;
    logic [1:0] ack;
    logic       chk;
    logic [7:0] gc;
  } vec_t;

  typedef struct {
    string      nm;
    logic [3:0] st;
    logic [1:0] len;
    logic [1:0] ack;
    logic       chk;
    logic [7:0] gc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  clk_gate_ctrl #(.NUM_DOM(ND), .IDLE_CYC(4), .WAKE_CYC(2), .STAT_W(SW)) dut (
    .clk(clk), .rst(rst), .glb_gate_en(glb_gate_en), .force_on(force_on),
    .dom_idle(dom_idle), .wake_req(wake_req), .wake_ack(wake_ack),
    .local_en(local_en), .dom_state(dom_state), .stat_clr(stat_clr),
    .gated_cyc(gated_cyc)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] g(input logic [7:0] x);
`ifdef CLK_GATE_STAT_EN
    return x;
`else
    return 8'h00 & x;
`endif
  endfunction

  function automatic vec_t mk(input logic glb, input logic [1:0] frc, input logic [1:0] idl,
                              input logic [1:0] wrq, input logic clr, input logic [3:0] st,
                              input logic [1:0] len, input logic [1:0] ack, input logic chk,
                              input logic [7:0] gc);
    vec_t v;
    v.glb = glb; v.frc = frc; v.idl = idl; v.wrq = wrq; v.clr = clr;
    v.st = st; v.len = len; v.ack = ack; v.chk = chk; v.gc = g(gc);
    return v;
  endfunction

  task automatic pop_check();
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: no expectation queued at %0t", $time);
    end else begin
      e = sb.pop_front();
      if (dom_state !== e.st || local_en !== e.len || wake_ack !== e.ack ||
          (e.chk && gated_cyc !== e.gc)) begin
        n_err++;
        $display("FAIL %s: dom_state=%b exp %b, local_en=%b exp %b, wake_ack=%b exp %b, gated_cyc=%h exp %h (chk=%0b)",
                 e.nm, dom_state, e.st, local_en, e.len, wake_ack, e.ack, gated_cyc, e.gc, e.chk);
      end
    end
  endtask

  task automatic push_exp(input string nm, input vec_t v);
    exp_t e;
    e.nm = nm; e.st = v.st; e.len = v.len; e.ack = v.ack; e.chk = v.chk; e.gc = v.gc;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, sample on the falling edge, return just after the next rising edge
  task automatic apply(input string nm, input vec_t v);
    glb_gate_en = v.glb; force_on = v.frc; dom_idle = v.idl; wake_req = v.wrq; stat_clr = v.clr;
    push_exp(nm, v);
    @(negedge clk);
    pop_check();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string nm, input vec_t v);
    push_exp(nm, v);
    pop_check();
  endtask

  initial begin
    // Gating, wake handshake, HYST abort and force_on hold; row k is cycle k after reset
    tbl.push_back(mk(1, 2'b00, 2'b01, 2'b00, 0, 4'b0000, 2'b11, 2'b00, 1, 8'h00));
    for (int i = 1; i <= 4; i++)
      tbl.push_back(mk(1, 2'b00, 2'b01, 2'b00, 0, 4'b0001, 2'b11, 2'b00, 1, 8'h00));
    tbl.push_back(mk(1, 2'b00, 2'b01, 2'b00, 0, 4'b0010, 2'b10, 2'b00, 1, 8'h00));
    tbl.push_back(mk(1, 2'b00, 2'b01, 2'b00, 0, 4'b0010, 2'b10, 2'b00, 1, 8'h01));
    tbl.push_back(mk(1, 2'b00, 2'b01, 2'b01, 0, 4'b0010, 2'b10, 2'b00, 1, 8'h02));
    tbl.push_back(mk(1, 2'b00, 2'b01, 2'b01, 0, 4'b0011, 2'b11, 2'b00, 1, 8'h03));
    tbl.push_back(mk(1, 2'b00, 2'b01, 2'b01, 0, 4'b0011, 2'b11, 2'b00, 1, 8'h03));
    tbl.push_back(mk(1, 2'b00, 2'b01, 2'b01, 0, 4'b0000, 2'b11, 2'b01, 1, 8'h03));
    tbl.push_back(mk(1, 2'b00, 2'b01, 2'b01, 0, 4'b0000, 2'b11, 2'b01, 1, 8'h03));
    tbl.push_back(mk(1, 2'b00, 2'b01, 2'b00, 0, 4'b0000, 2'b11, 2'b00, 1, 8'h03));
    tbl.push_back(mk(1, 2'b00, 2'b01, 2'b00, 0, 4'b0001, 2'b11, 2'b00, 1, 8'h03));
    tbl.push_back(mk(1, 2'b00, 2'b01, 2'b00, 0, 4'b0001, 2'b11, 2'b00, 1, 8'h03));
    tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 4'b0001, 2'b11, 2'b00, 1, 8'h03));
    tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 2'b11, 2'b00, 1, 8'h03));
    for (int i = 0; i < 20; i++)
      tbl.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 4'b0000, 2'b11, 2'b00, 1, 8'h03));

    rst = 1'b1; glb_gate_en = 1'b0; force_on = '0; dom_idle = '0; wake_req = '0; stat_clr = 1'b0;
    #3;
    expect_now("reset_initial", mk(0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 2'b11, 2'b00, 1, 8'h00));
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      apply($sformatf("table_row_%0d", i), tbl[i]);

    // Both domains gated, then master enable drops
    apply("both_on", mk(1, 2'b00, 2'b11, 2'b00, 0, 4'b0000, 2'b11, 2'b00, 1, 8'h03));
    for (int i = 1; i <= 4; i++)
      apply($sformatf("both_hyst_%0d", i), mk(1, 2'b00, 2'b11, 2'b00, 0, 4'b0101, 2'b11, 2'b00, 1, 8'h03));
    apply("both_off", mk(1, 2'b00, 2'b11, 2'b00, 0, 4'b1010, 2'b00, 2'b00, 1, 8'h03));
    apply("glb_fall", mk(0, 2'b00, 2'b11, 2'b00, 0, 4'b1010, 2'b00, 2'b00, 1, 8'h14));
    apply("glb_wake_1", mk(0, 2'b00, 2'b11, 2'b00, 0, 4'b1111, 2'b11, 2'b00, 1, 8'h25));
    apply("glb_wake_2", mk(0, 2'b00, 2'b11, 2'b00, 0, 4'b1111, 2'b11, 2'b00, 1, 8'h25));
    apply("glb_on", mk(0, 2'b00, 2'b11, 2'b00, 0, 4'b0000, 2'b11, 2'b00, 1, 8'h25));

    // Drive domain 0 into WAKE, then assert reset asynchronously mid-cycle
    apply("rw_on", mk(1, 2'b00, 2'b01, 2'b00, 0, 4'b0000, 2'b11, 2'b00, 0, 8'h00));
    for (int i = 1; i <= 4; i++)
      apply($sformatf("rw_hyst_%0d", i), mk(1, 2'b00, 2'b01, 2'b00, 0, 4'b0001, 2'b11, 2'b00, 0, 8'h00));
    apply("rw_off", mk(1, 2'b00, 2'b01, 2'b00, 0, 4'b0010, 2'b10, 2'b00, 0, 8'h00));
    apply("rw_req", mk(1, 2'b00, 2'b01, 2'b01, 0, 4'b0010, 2'b10, 2'b00, 0, 8'h00));
    apply("rw_wake", mk(1, 2'b00, 2'b01, 2'b01, 0, 4'b0011, 2'b11, 2'b00, 0, 8'h00));
    #2 rst = 1'b1;
    #1;
    expect_now("reset_mid_wake", mk(1, 2'b00, 2'b01, 2'b01, 0, 4'b0000, 2'b11, 2'b00, 1, 8'h00));
    @(posedge clk); #1;
    rst = 1'b0;

    // Gated-cycle statistics: count, clear, saturate
    for (int j = 0; j <= 15; j++)
      apply($sformatf("stat_run_%0d", j),
            mk(1, 2'b00, 2'b01, 2'b00, (j == 15),
               (j == 0) ? 4'b0000 : ((j < 5) ? 4'b0001 : 4'b0010),
               (j < 5) ? 2'b11 : 2'b10, 2'b00, 1, (j <= 5) ? 8'h00 : 8'(j - 5)));
    for (int m = 0; m <= 20; m++)
      apply($sformatf("stat_after_clr_%0d", m),
            mk(1, 2'b00, 2'b01, 2'b00, 0, 4'b0010, 2'b10, 2'b00, 1, (m >= 15) ? 8'h0f : 8'(m)));

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: %0d expectations not consumed, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
